// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and default widths for the APB request arbiter slice.
package apb_req_arbiter_pkg;
  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } apb_state_e;
endpackage

// File: rtl/apb_req_arbiter_if.sv
// APB master-side bus bundle (clk_a domain, upstream of the async bridge).
interface apb_req_arbiter_if
  import apb_req_arbiter_pkg::*;
#(
  parameter int AW = APB_AW,
  parameter int DW = APB_DW
);
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic          pready;
  logic [DW-1:0] prdata;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  pready, prdata
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output pready, prdata
  );
endinterface

// File: rtl/apb_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      gnt_id,
  output logic               gnt_vld
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [PW-1:0]        off;
  logic [PW:0]          sum;

  // Rotate so bit 0 is ptr; the lowest set bit is then the winner offset.
  always_comb begin
    dbl     = {req, req} >> ptr;
    rot     = dbl[NUM_REQ-1:0];
    gnt_vld = |rot;
    off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) off = PW'(k);
    sum    = {1'b0, ptr} + {1'b0, off};
    gnt_id = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
  end
endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ req/done requesters,
// with an ACCESS-phase timeout that completes the transfer with rsp_err=1.
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int AW      = APB_AW,
  parameter  int DW      = APB_DW,
  parameter  int TIMEOUT = 64,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ-1:0][AW-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DW-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]           done,
  output logic [DW-1:0]                rsp_rdata,
  output logic                         rsp_err,
  apb_req_arbiter_if.master            apb
);
  localparam int            TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] gnt_id;
  logic          gnt_vld;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      win         <= '0;
      tcnt        <= '0;
      done        <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
      apb.pwrite  <= 1'b0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            win        <= gnt_id;
            apb.paddr  <= req_addr[gnt_id];
            apb.pwdata <= req_wdata[gnt_id];
            apb.pwrite <= req_write[gnt_id];
            apb.psel   <= 1'b1;
            tcnt       <= '0;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          apb.penable <= 1'b1;
          state       <= S_ACCESS;
        end
        S_ACCESS: begin
          if (apb.pready) begin
            rsp_rdata   <= apb.pwrite ? '0 : apb.prdata;
            rsp_err     <= 1'b0;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            done[win]   <= 1'b1;
            state       <= S_RESP;
          end else if (TIMEOUT != 0 && tcnt == TLAST) begin
            // Slave never answered: complete with an error so the requester is released.
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            done[win]   <= 1'b1;
            state       <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESP: begin
          ptr   <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed + random bench for apb_req_arbiter against a transaction-timeline reference model.
module tb_apb_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N-1:0]         req = '0;
  logic [N-1:0]         req_write = '0;
  logic [N-1:0][AW-1:0] req_addr = '0;
  logic [N-1:0][DW-1:0] req_wdata = '0;
  logic [N-1:0]         done;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;

  apb_req_arbiter_if #(.AW(AW), .DW(DW)) apb ();

  apb_req_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  // reference model: one transaction in flight, described by grant cycle and wait count
  bit            busy = 0;
  int            g, w, nacc, win;
  int            ptr_m = 0;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_err;
  bit   [N-1:0]  outst = '0, pend = '0, rereq = '0, done_seen = '0;
  int            next_w = -1;
  bit            drop_next = 0, fix_rd = 0, rand_mode = 0;
  int            grants[$];
  int            acc_obs = 0, last_done_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spawn(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i] = wr;
    req_addr[i]  = a;
    req_wdata[i] = d;
    outst[i]     = 1'b1;
    pend[i]      = 1'b1;
  endtask

  task automatic step();
    int k;
    logic e_psel, e_pen;
    logic [N-1:0] e_done;
    bit just_done;
    @(negedge clk);
    cyc++;
    e_psel = 0; e_pen = 0; e_done = '0; just_done = 0; k = 0;
    if (busy) begin
      k = cyc - g;
      if (k >= 1 && k <= 1 + nacc) begin
        e_psel = 1'b1;
        e_pen  = (k >= 2);
      end
      if (k == 2 + nacc) e_done = N'(1) << win;
    end
    chk("psel", 64'(apb.psel), 64'(e_psel));
    chk("penable", 64'(apb.penable), 64'(e_pen));
    chk("done", 64'(done), 64'(e_done));
    if (apb.penable) acc_obs++;
    if (|done) begin
      done_seen     = done_seen | done;
      last_done_cyc = cyc;
    end
    if (e_psel) begin
      chk("paddr", 64'(apb.paddr), 64'(m_addr));
      chk("pwrite", 64'(apb.pwrite), 64'(m_wr));
      chk("pwdata", 64'(apb.pwdata), 64'(m_wdata));
    end
    if (busy && k == 2 + nacc) begin
      chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
      busy       = 0;
      just_done  = 1;
      ptr_m      = (win + 1) % N;
      req[win]   = rereq[win];
      outst[win] = rereq[win];
    end
    // requester side
    if (rand_mode)
      for (int i = 0; i < N; i++)
        if (!outst[i] && $urandom_range(3) == 0)
          spawn(i, 1'($urandom_range(1)), AW'($urandom), DW'($urandom));
    req  = req | pend;
    pend = '0;
    if (busy && cyc - g == 2 && (drop_next || (rand_mode && $urandom_range(7) == 0))) begin
      req[win]  = 1'b0;
      drop_next = 0;
    end
    // arbitration in IDLE: first requester at or after ptr, wrapping
    if (!busy && !just_done) begin
      for (int off = N - 1; off >= 0; off--)
        if (req[(ptr_m + off) % N]) win = (ptr_m + off) % N;
      if (|req) begin
        busy    = 1;
        g       = cyc;
        w       = (next_w >= 0) ? next_w : (($urandom_range(9) == 0) ? 20 : int'($urandom_range(3)));
        nacc    = (w >= TO) ? TO : w + 1;
        m_err   = (w >= TO);
        m_rdata = '0;
        m_wr    = req_write[win];
        m_addr  = req_addr[win];
        m_wdata = req_wdata[win];
        grants.push_back(win);
      end
    end
    // slave side: pready only at the chosen wait cycle during ACCESS, noise elsewhere
    apb.prdata = fix_rd ? 32'hDEADBEEF : DW'($urandom);
    if (busy && (cyc - g) >= 2 && (cyc - g) < 2 + nacc) begin
      apb.pready = ((cyc - g - 2) == w);
      if (apb.pready) m_rdata = m_wr ? '0 : apb.prdata;
    end else begin
      apb.pready = 1'($urandom_range(1));
    end
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((busy || outst != '0) && n < max) begin
      step();
      n++;
    end
    if (busy || outst != '0) chk("run_bound", 64'(0), 64'(1));
  endtask

  task automatic run_grants(input int cnt, input int max);
    int n = 0;
    while (grants.size() < cnt && n < max) begin
      step();
      n++;
    end
    if (grants.size() < cnt) chk("grant_bound", 64'(0), 64'(1));
  endtask

  initial begin
    int base, g1;
    apb.pready = 1'b0;
    apb.prdata = '0;
    #1;
    chk("rst_psel", 64'(apb.psel), 64'(0));
    chk("rst_penable", 64'(apb.penable), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_paddr", 64'(apb.paddr), 64'(0));
    chk("rst_pwdata", 64'(apb.pwdata), 64'(0));
    chk("rst_pwrite", 64'(apb.pwrite), 64'(0));
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_err", 64'(rsp_err), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // single read, two wait states, fixed read data
    fix_rd = 1; next_w = 2;
    spawn(0, 1'b0, 32'h10, 32'h0);
    run_grants(1, 20);
    g1 = g;
    run_idle(30);
    chk("s1_latency", 64'(last_done_cyc - g1), 64'(5));
    chk("s1_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    fix_rd = 0;

    // async reset in the middle of ACCESS
    next_w = 5;
    spawn(2, 1'b0, 32'h200, 32'h0);
    base = 0;
    while (!(busy && cyc - g >= 3) && base < 30) begin step(); base++; end
    chk("s5_in_access", 64'(apb.penable), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("s5_psel", 64'(apb.psel), 64'(0));
    chk("s5_penable", 64'(apb.penable), 64'(0));
    chk("s5_done", 64'(done), 64'(0));
    busy = 0; ptr_m = 0; outst = '0; pend = '0; req = '0;
    @(negedge clk);
    rst = 1'b1;
    // ptr must be back at 0: requester 0 beats 3
    next_w = 1;
    base = grants.size();
    spawn(0, 1'b1, 32'h0A0, 32'h1111);
    spawn(3, 1'b1, 32'h3A0, 32'h3333);
    run_idle(40);
    chk("s5_ptr_first", 64'(grants[base]), 64'(0));
    chk("s5_ptr_second", 64'(grants[base+1]), 64'(3));

    // all four zero-wait writes from ptr=0
    next_w = 0;
    base = grants.size();
    for (int i = 0; i < N; i++) spawn(i, 1'b1, AW'(32'h1000 + i * 16), DW'($urandom));
    run_idle(60);
    for (int i = 0; i < N; i++) chk("s2_order", 64'(grants[base+i]), 64'(i));

    // fairness: req0 held through its own done while req2 waits
    next_w = 1;
    base = grants.size();
    rereq[0] = 1'b1;
    spawn(0, 1'b0, 32'h40, 32'h0);
    run_grants(base + 1, 20);
    spawn(2, 1'b1, 32'h240, 32'h2222);
    run_grants(base + 3, 40);
    rereq[0] = 1'b0;
    run_idle(40);
    chk("s3_g0", 64'(grants[base]), 64'(0));
    chk("s3_g1", 64'(grants[base+1]), 64'(2));
    chk("s3_g2", 64'(grants[base+2]), 64'(0));

    // timeout: pready never comes back
    next_w = 99;
    acc_obs = 0;
    spawn(1, 1'b0, 32'h180, 32'h0);
    run_idle(40);
    chk("s4_access_cycles", 64'(acc_obs), 64'(TO));
    chk("s4_err", 64'(rsp_err), 64'(1));
    chk("s4_rdata", 64'(rsp_rdata), 64'(0));
    next_w = 1;
    spawn(3, 1'b0, 32'h380, 32'h0);
    run_idle(40);
    chk("s4_next_err", 64'(rsp_err), 64'(0));

    // requester drops req during ACCESS
    next_w = 3; drop_next = 1; done_seen = '0;
    spawn(2, 1'b0, 32'h2C0, 32'h0);
    run_idle(40);
    chk("s6_done_seen", 64'(done_seen[2]), 64'(1));

    // random traffic
    next_w = -1; rand_mode = 1;
    for (int i = 0; i < 1500; i++) step();
    rand_mode = 0;
    run_idle(400);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
